// File: rtl/ahb_lite_master_bridge_if.sv
// Signal bundle for the AHB-Lite master bridge: command stream, response
// stream and the AHB-Lite master/slave bus signals.
//
// Handshake rule for both streams: a beat transfers on a rising clock edge
// where valid and ready are both high. Once valid is raised, the producer
// holds valid and its payload steady until that edge. The consumer may raise
// or lower ready at any time.
interface ahb_lite_master_bridge_if;
   // command stream (caller -> bridge)
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [31:0] cmd_addr;
   logic [2:0]  cmd_size;
   logic [31:0] cmd_wdata;
   // response stream (bridge -> caller)
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        rsp_timeout;
   // AHB-Lite master outputs
   logic [31:0] HADDR;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [1:0]  HTRANS;
   logic [31:0] HWDATA;
   logic [2:0]  HBURST;
   logic [3:0]  HPROT;
   logic        HMASTLOCK;
   // AHB-Lite slave returns
   logic [31:0] HRDATA;
   logic        HREADY;
   logic        HRESP;

   // bridge side
   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
      output cmd_ready,
      output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
      input  rsp_ready,
      output HADDR, HWRITE, HSIZE, HTRANS, HWDATA, HBURST, HPROT, HMASTLOCK,
      input  HRDATA, HREADY, HRESP
   );

   // caller and bus-slave side
   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
      input  cmd_ready,
      input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
      output rsp_ready,
      input  HADDR, HWRITE, HSIZE, HTRANS, HWDATA, HBURST, HPROT, HMASTLOCK,
      output HRDATA, HREADY, HRESP
   );
endinterface

// File: rtl/ahb_lite_master_bridge.sv
// Single-outstanding AHB-Lite master. Each accepted command becomes one
// SINGLE transfer (address phase, data phase) and produces exactly one
// response beat. Misaligned commands are answered with an error and never
// reach the bus. A data phase stretched past TIMEOUT wait cycles is
// abandoned and answered with rsp_timeout.
module ahb_lite_master_bridge #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                            HCLK,
   input  logic                            HRESET,
   ahb_lite_master_bridge_if.master        bus,
   output logic [1:0]                      dbg_state_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADDR = 2'd1,
      S_DATA = 2'd2,
      S_RESP = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic        write_q, write_d;
   logic [31:0] addr_q, addr_d;
   logic [2:0]  size_q, size_d;
   logic [31:0] wdata_q, wdata_d;
   logic [15:0] wait_cnt_q, wait_cnt_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic        timeout_q, timeout_d;

   logic        misaligned;

   // Alignment is judged on the incoming command so the decision is made in
   // the acceptance cycle; size codes above word are treated as misaligned.
   always_comb begin
      misaligned = 1'b0;
      if (bus.cmd_size > 3'd2) begin
         misaligned = 1'b1;
      end else if (bus.cmd_size == 3'd1 && bus.cmd_addr[0]) begin
         misaligned = 1'b1;
      end else if (bus.cmd_size == 3'd2 && bus.cmd_addr[1:0] != 2'b00) begin
         misaligned = 1'b1;
      end
   end

   // Next-state and datapath update for the transfer sequencer.
   always_comb begin
      state_d    = state_q;
      write_d    = write_q;
      addr_d     = addr_q;
      size_d     = size_q;
      wdata_d    = wdata_q;
      wait_cnt_d = wait_cnt_q;
      rdata_d    = rdata_q;
      err_d      = err_q;
      timeout_d  = timeout_q;

      unique case (state_q)
         S_IDLE: begin
            if (bus.cmd_valid) begin
               write_d    = bus.cmd_write;
               addr_d     = bus.cmd_addr;
               size_d     = bus.cmd_size;
               wdata_d    = bus.cmd_wdata;
               wait_cnt_d = 16'd0;
               rdata_d    = 32'd0;
               err_d      = 1'b0;
               timeout_d  = 1'b0;
               if (misaligned) begin
                  err_d   = 1'b1;
                  state_d = S_RESP;
               end else begin
                  state_d = S_ADDR;
               end
            end
         end

         S_ADDR: begin
            // The address phase completes on the first edge with HREADY high.
            if (bus.HREADY) begin
               wait_cnt_d = 16'd0;
               state_d    = S_DATA;
            end
         end

         S_DATA: begin
            if (bus.HREADY) begin
               // Completion; an ERROR here is the second cycle of the
               // two-cycle error response, so no data is returned.
               if (bus.HRESP) begin
                  err_d   = 1'b1;
                  rdata_d = 32'd0;
               end else begin
                  rdata_d = write_q ? 32'd0 : bus.HRDATA;
               end
               state_d = S_RESP;
            end else if (wait_cnt_q == 16'(TIMEOUT)) begin
               timeout_d = 1'b1;
               rdata_d   = 32'd0;
               state_d   = S_RESP;
            end else begin
               wait_cnt_d = wait_cnt_q + 16'd1;
            end
         end

         S_RESP: begin
            if (bus.rsp_ready) begin
               state_d = S_IDLE;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // State and latched-command registers; reset abandons any transfer.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q    <= S_IDLE;
         write_q    <= 1'b0;
         addr_q     <= 32'd0;
         size_q     <= 3'd0;
         wdata_q    <= 32'd0;
         wait_cnt_q <= 16'd0;
         rdata_q    <= 32'd0;
         err_q      <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         write_q    <= write_d;
         addr_q     <= addr_d;
         size_q     <= size_d;
         wdata_q    <= wdata_d;
         wait_cnt_q <= wait_cnt_d;
         rdata_q    <= rdata_d;
         err_q      <= err_d;
         timeout_q  <= timeout_d;
      end
   end

   // Outputs decode only registered state, so no input reaches an output
   // combinationally. Address signals are shown only during the address
   // phase and write data only during the data phase.
   assign bus.cmd_ready   = (state_q == S_IDLE);
   assign bus.rsp_valid   = (state_q == S_RESP);
   assign bus.rsp_rdata   = (state_q == S_RESP) ? rdata_q : 32'd0;
   assign bus.rsp_err     = (state_q == S_RESP) ? err_q : 1'b0;
   assign bus.rsp_timeout = (state_q == S_RESP) ? timeout_q : 1'b0;

   assign bus.HTRANS    = (state_q == S_ADDR) ? 2'b10 : 2'b00;
   assign bus.HADDR     = (state_q == S_ADDR) ? addr_q : 32'd0;
   assign bus.HWRITE    = (state_q == S_ADDR) ? write_q : 1'b0;
   assign bus.HSIZE     = (state_q == S_ADDR) ? size_q : 3'd0;
   assign bus.HWDATA    = (state_q == S_DATA && write_q) ? wdata_q : 32'd0;
   assign bus.HBURST    = 3'b000;
   assign bus.HPROT     = 4'b0011;
   assign bus.HMASTLOCK = 1'b0;

   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ahb_lite_master_bridge.sv
// Bench for ahb_lite_master_bridge: a reactive AHB-Lite slave with
// programmable address/data wait states and error responses, plus scenario
// tasks checked against a transaction-level model of latency and results.
module tb_ahb_lite_master_bridge;

   localparam int TMO = 4;

   logic       HCLK;
   logic       HRESET;
   logic [1:0] dbg_state;
   int         checks;
   int         passes;

   ahb_lite_master_bridge_if bus_if ();

   ahb_lite_master_bridge #(.TIMEOUT(TMO)) dut (
      .HCLK        (HCLK),
      .HRESET      (HRESET),
      .bus         (bus_if.master),
      .dbg_state_o (dbg_state)
   );

   // clock / reset
   initial begin
      HCLK = 1'b0;
      forever #5 HCLK = ~HCLK;
   end

   // slave behaviour settings, chosen per transaction
   int          s_aw;
   int          s_dw;
   logic        s_err;
   logic [31:0] s_rdata;
   logic        slave_rst;
   // slave phase tracking
   logic        data_act;
   int          dcnt;
   int          acnt;
   logic        last_ready;
   logic        last_accept;
   logic        rst_seen;

   // reactive slave: decides HREADY/HRESP/HRDATA for each cycle just after the edge
   initial begin
      data_act = 1'b0; dcnt = 0; acnt = 0;
      last_ready = 1'b1; last_accept = 1'b0; slave_rst = 1'b0;
      s_aw = 0; s_dw = 0; s_err = 1'b0; s_rdata = 32'd0;
      bus_if.HREADY = 1'b1; bus_if.HRESP = 1'b0; bus_if.HRDATA = 32'd0;
      forever begin
         @(posedge HCLK);
         rst_seen = HRESET;
         #1;
         if (rst_seen || slave_rst) begin
            data_act = 1'b0; acnt = 0; dcnt = 0;
            last_accept = 1'b0; slave_rst = 1'b0;
         end else begin
            if (data_act && last_ready) data_act = 1'b0;
            if (last_accept) begin
               data_act = 1'b1;
               dcnt = 0;
            end
         end
         bus_if.HRESP  = 1'b0;
         bus_if.HREADY = 1'b1;
         bus_if.HRDATA = $urandom;
         if (data_act) begin
            if (dcnt < s_dw) begin
               bus_if.HREADY = 1'b0;
               bus_if.HRESP  = (s_err && dcnt == s_dw - 1);
            end else begin
               bus_if.HRESP  = s_err;
               bus_if.HRDATA = s_rdata;
            end
            dcnt++;
         end else if (bus_if.HTRANS == 2'b10) begin
            bus_if.HREADY = (acnt >= s_aw);
            acnt++;
         end else begin
            acnt = 0;
         end
         last_ready  = bus_if.HREADY;
         last_accept = (bus_if.HTRANS == 2'b10) && bus_if.HREADY;
      end
   end

   // Driver + checker for one command. The expected response is derived from
   // the command and the slave's wait/error plan.
   task automatic run_txn(input string tag, input logic wr, input logic [31:0] addr,
                          input logic [2:0] size, input logic [31:0] wdata,
                          input int aw, input int dw, input logic err,
                          input logic [31:0] rdata, input int hold);
      logic        mis;
      int          exp_lat, exp_ns, c, lat, ns_cycles;
      logic [31:0] exp_rd, rd0, exp_wd;
      logic        exp_err, exp_tmo, e0, t0;
      logic        addr_bad, wd_bad, ready_bad, hold_bad;

      mis = (size > 3'd2) || (size == 3'd1 && addr[0]) || (size == 3'd2 && addr[1:0] != 2'b00);
      exp_wd = wr ? wdata : 32'd0;
      if (mis) begin
         exp_lat = 1; exp_ns = 0; exp_err = 1'b1; exp_tmo = 1'b0; exp_rd = 32'd0;
      end else if (dw > TMO) begin
         exp_lat = aw + TMO + 3; exp_ns = aw + 1; exp_err = 1'b0; exp_tmo = 1'b1; exp_rd = 32'd0;
      end else begin
         exp_lat = aw + dw + 3; exp_ns = aw + 1; exp_err = err; exp_tmo = 1'b0;
         exp_rd = (wr || err) ? 32'd0 : rdata;
      end

      s_aw = aw; s_dw = dw; s_err = err; s_rdata = rdata; slave_rst = 1'b1;
      @(negedge HCLK);
      bus_if.cmd_valid = 1'b1; bus_if.cmd_write = wr; bus_if.cmd_addr = addr;
      bus_if.cmd_size = size; bus_if.cmd_wdata = wdata;
      checks++;
      if (bus_if.cmd_ready !== 1'b1) $display("FAIL %s cmd_ready: got %b expected 1", tag, bus_if.cmd_ready);
      else passes++;
      @(posedge HCLK);

      c = 0; lat = -1; ns_cycles = 0;
      addr_bad = 1'b0; wd_bad = 1'b0; ready_bad = 1'b0;
      while (lat < 0 && c < 400) begin
         @(negedge HCLK);
         c++;
         if (c == 1) bus_if.cmd_valid = 1'b0;
         if (bus_if.rsp_valid === 1'b1) begin
            lat = c;
         end else begin
            if (bus_if.cmd_ready !== 1'b0) ready_bad = 1'b1;
            if (bus_if.HTRANS === 2'b10) begin
               ns_cycles++;
               if (bus_if.HADDR !== addr || bus_if.HWRITE !== wr || bus_if.HSIZE !== size) addr_bad = 1'b1;
            end else if (bus_if.HTRANS !== 2'b00) begin
               addr_bad = 1'b1;
            end
            if (data_act && bus_if.HWDATA !== exp_wd) wd_bad = 1'b1;
         end
      end

      checks++;
      if (lat != exp_lat) $display("FAIL %s latency: got %0d expected %0d", tag, lat, exp_lat);
      else passes++;
      if (lat < 0) begin
         bus_if.rsp_ready = 1'b0;
         return;
      end
      checks++;
      if (bus_if.rsp_rdata !== exp_rd) $display("FAIL %s rdata: got %h expected %h", tag, bus_if.rsp_rdata, exp_rd);
      else passes++;
      checks++;
      if (bus_if.rsp_err !== exp_err) $display("FAIL %s err: got %b expected %b", tag, bus_if.rsp_err, exp_err);
      else passes++;
      checks++;
      if (bus_if.rsp_timeout !== exp_tmo) $display("FAIL %s timeout: got %b expected %b", tag, bus_if.rsp_timeout, exp_tmo);
      else passes++;
      checks++;
      if (ns_cycles != exp_ns) $display("FAIL %s nonseq_cycles: got %0d expected %0d", tag, ns_cycles, exp_ns);
      else passes++;
      checks++;
      if (addr_bad !== 1'b0) $display("FAIL %s addr_phase: got bad=%b expected 0", tag, addr_bad);
      else passes++;
      checks++;
      if (wd_bad !== 1'b0) $display("FAIL %s hwdata: got bad=%b expected 0", tag, wd_bad);
      else passes++;
      checks++;
      if (ready_bad !== 1'b0) $display("FAIL %s busy_cmd_ready: got bad=%b expected 0", tag, ready_bad);
      else passes++;

      // response held under backpressure
      rd0 = bus_if.rsp_rdata; e0 = bus_if.rsp_err; t0 = bus_if.rsp_timeout;
      hold_bad = 1'b0;
      for (int h = 0; h < hold; h++) begin
         @(negedge HCLK);
         if (bus_if.rsp_valid !== 1'b1 || bus_if.cmd_ready !== 1'b0 || bus_if.HTRANS !== 2'b00 ||
             bus_if.rsp_rdata !== rd0 || bus_if.rsp_err !== e0 || bus_if.rsp_timeout !== t0)
            hold_bad = 1'b1;
      end
      if (hold > 0) begin
         checks++;
         if (hold_bad !== 1'b0) $display("FAIL %s hold_stable: got bad=%b expected 0", tag, hold_bad);
         else passes++;
      end

      bus_if.rsp_ready = 1'b1;
      @(posedge HCLK);
      @(negedge HCLK);
      bus_if.rsp_ready = 1'b0;
      checks++;
      if (bus_if.rsp_valid !== 1'b0 || bus_if.cmd_ready !== 1'b1)
         $display("FAIL %s after_handshake: got valid=%b ready=%b expected valid=0 ready=1",
                  tag, bus_if.rsp_valid, bus_if.cmd_ready);
      else passes++;
   endtask

   task automatic check_reset_values(input string tag);
      checks++;
      if ({bus_if.cmd_ready, bus_if.rsp_valid, bus_if.rsp_rdata, bus_if.rsp_err, bus_if.rsp_timeout} !== {1'b1, 1'b0, 32'd0, 1'b0, 1'b0})
         $display("FAIL %s stream_outputs: got ready=%b valid=%b rdata=%h err=%b tmo=%b expected 1 0 0 0 0",
                  tag, bus_if.cmd_ready, bus_if.rsp_valid, bus_if.rsp_rdata, bus_if.rsp_err, bus_if.rsp_timeout);
      else passes++;
      checks++;
      if ({bus_if.HADDR, bus_if.HWRITE, bus_if.HSIZE, bus_if.HTRANS, bus_if.HWDATA} !== 70'd0)
         $display("FAIL %s bus_outputs: got addr=%h wr=%b size=%0d trans=%b wdata=%h expected all 0",
                  tag, bus_if.HADDR, bus_if.HWRITE, bus_if.HSIZE, bus_if.HTRANS, bus_if.HWDATA);
      else passes++;
      checks++;
      if ({bus_if.HBURST, bus_if.HPROT, bus_if.HMASTLOCK} !== {3'b000, 4'b0011, 1'b0})
         $display("FAIL %s const_outputs: got burst=%b prot=%b lock=%b expected 000 0011 0",
                  tag, bus_if.HBURST, bus_if.HPROT, bus_if.HMASTLOCK);
      else passes++;
   endtask

   task automatic test_reset();
      HRESET = 1'b1;
      repeat (3) @(posedge HCLK);
      @(negedge HCLK);
      check_reset_values("reset");
      HRESET = 1'b0;
   endtask

   task automatic test_aligned_write();
      run_txn("write_zero_wait", 1'b1, 32'h1000_0004, 3'd2, 32'hDEAD_BEEF, 0, 0, 1'b0, 32'h1234_5678, 0);
   endtask

   task automatic test_byte_read_wait();
      run_txn("byte_read_2wait", 1'b0, 32'h1000_0003, 3'd0, 32'd0, 0, 2, 1'b0, 32'h5A00_0000, 0);
      run_txn("half_read_addr_wait", 1'b0, 32'h2000_0102, 3'd1, 32'd0, 2, 1, 1'b0, 32'h0000_A5C3, 1);
   endtask

   task automatic test_error();
      run_txn("error_read", 1'b0, 32'h3000_0010, 3'd2, 32'd0, 0, 1, 1'b1, 32'hFFFF_FFFF, 0);
      run_txn("error_write_waits", 1'b1, 32'h3000_0020, 3'd2, 32'hCAFE_F00D, 1, 3, 1'b1, 32'h1111_1111, 0);
   endtask

   task automatic test_timeout();
      run_txn("timeout_read", 1'b0, 32'h4000_0000, 3'd2, 32'd0, 0, 60, 1'b0, 32'h7777_7777, 0);
      run_txn("max_wait_no_timeout", 1'b0, 32'h4000_0004, 3'd2, 32'd0, 0, TMO, 1'b0, 32'h0BAD_CAFE, 0);
      run_txn("one_past_timeout", 1'b1, 32'h4000_0008, 3'd2, 32'h0F0F_0F0F, 0, TMO + 1, 1'b0, 32'd0, 0);
   endtask

   task automatic test_misaligned();
      run_txn("misaligned_word", 1'b1, 32'h0000_0002, 3'd2, 32'hAAAA_5555, 0, 0, 1'b0, 32'd0, 0);
      run_txn("misaligned_half", 1'b0, 32'h0000_0101, 3'd1, 32'd0, 0, 0, 1'b0, 32'd0, 0);
      run_txn("bad_size", 1'b0, 32'h0000_0100, 3'd3, 32'd0, 0, 0, 1'b0, 32'd0, 0);
   endtask

   task automatic test_backpressure();
      run_txn("backpressure_read", 1'b0, 32'h5000_0008, 3'd2, 32'd0, 0, 1, 1'b0, 32'h8765_4321, 5);
      run_txn("backpressure_mis", 1'b1, 32'h5000_0001, 3'd2, 32'd0, 0, 0, 1'b0, 32'd0, 5);
   endtask

   task automatic test_reset_mid();
      s_aw = 0; s_dw = 3; s_err = 1'b0; s_rdata = 32'h1357_9BDF; slave_rst = 1'b1;
      @(negedge HCLK);
      bus_if.cmd_valid = 1'b1; bus_if.cmd_write = 1'b1; bus_if.cmd_addr = 32'h6000_0000;
      bus_if.cmd_size = 3'd2; bus_if.cmd_wdata = 32'h2468_ACE0;
      @(posedge HCLK);
      @(negedge HCLK);
      bus_if.cmd_valid = 1'b0;
      @(negedge HCLK);
      checks++;
      if (bus_if.HWDATA !== 32'h2468_ACE0) $display("FAIL reset_mid data_phase: got %h expected 2468ace0", bus_if.HWDATA);
      else passes++;
      HRESET = 1'b1;
      bus_if.rsp_ready = 1'b1;
      @(negedge HCLK);
      HRESET = 1'b0;
      check_reset_values("reset_mid");
      begin
         int seen = 0;
         for (int i = 0; i < 8; i++) begin
            @(negedge HCLK);
            if (bus_if.rsp_valid === 1'b1) seen++;
         end
         checks++;
         if (seen != 0) $display("FAIL reset_mid no_response: got %0d response cycles expected 0", seen);
         else passes++;
      end
      bus_if.rsp_ready = 1'b0;
      run_txn("after_reset", 1'b0, 32'h6000_0010, 3'd2, 32'd0, 0, 0, 1'b0, 32'h0C0F_FEE0, 0);
   endtask

   task automatic test_back_to_back();
      int accepts, resps;
      s_aw = 0; s_dw = 0; s_err = 1'b0; s_rdata = 32'd0; slave_rst = 1'b1;
      accepts = 0; resps = 0;
      @(negedge HCLK);
      bus_if.cmd_valid = 1'b1; bus_if.cmd_write = 1'b1; bus_if.cmd_addr = 32'h7000_0000;
      bus_if.cmd_size = 3'd2; bus_if.cmd_wdata = 32'h5555_AAAA;
      bus_if.rsp_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         if (i > 0) @(negedge HCLK);
         if (bus_if.cmd_ready === 1'b1) accepts++;
         if (bus_if.rsp_valid === 1'b1) resps++;
      end
      @(negedge HCLK);
      bus_if.cmd_valid = 1'b0;
      bus_if.rsp_ready = 1'b0;
      checks++;
      if (accepts != 3) $display("FAIL back_to_back accepts: got %0d expected 3", accepts);
      else passes++;
      checks++;
      if (resps != 3) $display("FAIL back_to_back responses: got %0d expected 3", resps);
      else passes++;
   endtask

   task automatic test_random();
      for (int n = 0; n < 40; n++) begin
         logic [31:0] addr;
         logic [2:0]  size;
         int          dw;
         logic        err;
         addr = $urandom;
         if ($urandom_range(0, 5) == 0) begin
            size = 3'($urandom_range(0, 7));
         end else begin
            size = 3'($urandom_range(0, 2));
            if (size == 3'd1) addr[0] = 1'b0;
            if (size == 3'd2) addr[1:0] = 2'b00;
         end
         dw  = $urandom_range(0, TMO + 2);
         err = (dw >= 1 && dw <= TMO) ? 1'($urandom_range(0, 1)) : 1'b0;
         run_txn($sformatf("random_%0d", n), 1'($urandom_range(0, 1)), addr, size, $urandom,
                 $urandom_range(0, 2), dw, err, $urandom, $urandom_range(0, 3));
      end
   endtask

   initial begin
      checks = 0;
      passes = 0;
      HRESET = 1'b1;
      bus_if.cmd_valid = 1'b0; bus_if.cmd_write = 1'b0; bus_if.cmd_addr = 32'd0;
      bus_if.cmd_size = 3'd0; bus_if.cmd_wdata = 32'd0; bus_if.rsp_ready = 1'b0;
      test_reset();
      test_aligned_write();
      test_byte_read_wait();
      test_error();
      test_timeout();
      test_misaligned();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
